// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/carry_lookahead_adder_4bit.sv
// Combinational 4-bit carry-lookahead adder used as the nibble stage.
module carry_lookahead_adder_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = A ^ B;
    assign g = A & B;

    always_comb begin
        c    = '0;
        c[0] = Cin;
        c[1] = g[0] | (p[0] & Cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & Cin);
        Cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & Cin);
    end

    assign S = p ^ c;

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder: one nibble per cycle through a single 4-bit CLA,
// with the nibble carry registered between steps.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4, >= 4");
    end

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     ra;
    logic [WIDTH-1:0]     rb;
    logic [WIDTH-1:0]     part;
    logic                 carry;
    logic                 a_msb;
    logic                 b_msb;

    logic [NIBBLE_W-1:0]  s;
    logic                 co;
    logic [WIDTH+3:0]     cat;
    logic [WIDTH-1:0]     nxt;
    logic                 last;
    logic                 unused_low;

    carry_lookahead_adder_4bit u_cla (
        .A    (ra[NIBBLE_W-1:0]),
        .B    (rb[NIBBLE_W-1:0]),
        .Cin  (carry),
        .S    (s),
        .Cout (co)
    );

    // New nibble enters at the MSB end; the oldest nibble falls off.
    assign cat        = {s, part};
    assign nxt        = cat[WIDTH+3:NIBBLE_W];
    assign unused_low = ^cat[NIBBLE_W-1:0];
    assign last       = (cnt == CW'(NIB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ra       <= '0;
            rb       <= '0;
            part     <= '0;
            carry    <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        carry <= cin;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    ra    <= ra >> NIBBLE_W;
                    rb    <= rb >> NIBBLE_W;
                    part  <= nxt;
                    carry <= co;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        state    <= DONE;
                        sum      <= nxt;
                        cout     <= co;
                        overflow <= (a_msb == b_msb) &&
                                    (nxt[WIDTH-1] != a_msb);
                        done     <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Sequential multi-word adder that adds two WIDTH-bit operands one nibble per cycle through a single carry_lookahead_adder_4bit instance. Each nibble's carry-out is registered and fed back as the next nibble's carry-in. It sits directly upstream of the 4-bit CLA: it slices operands, drives the CLA, and consumes its S/Cout. It trades latency for area in datapaths wider than 4 bits.

Parameters:
WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4. Any other value is an elaboration error.
NIB, WIDTH/4, number of nibble steps. Derived localparam, not overridable.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A, captured when start is accepted
b  input  WIDTH  operand B, captured when start is accepted
cin  input  1  carry-in to nibble 0, captured when start is accepted
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse when the result is valid
sum  output  WIDTH  registered result
cout  output  1  registered carry-out of the MSB nibble
overflow  output  1  registered signed (two's complement) overflow

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE; counter=0; operand registers and carry register cleared.
  - sum=0, cout=0, overflow=0, busy=0, done=0.
  - An operation in flight is abandoned; no done is produced for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when start=1 at a clock edge. On that edge: capture a, b into shift registers; capture cin into the carry register; capture a[WIDTH-1] and b[WIDTH-1]; clear the counter.
  - RUN, each edge:
    - CLA inputs: A = low nibble of the A shift register, B = low nibble of the B shift register, Cin = carry register.
    - The CLA S nibble shifts into the MSB end of the partial-result register (shift right by 4).
    - A and B shift registers shift right by 4.
    - Carry register ← CLA Cout; counter increments.
  - RUN→DONE on the edge where counter == NIB-1. On that same edge:
    - sum ← completed result.
    - cout ← final CLA Cout.
    - overflow ← (a_msb == b_msb) && (sum MSB != a_msb).
  - DONE→IDLE unconditionally on the next edge.
- Outputs and handshake:
  - done=1 only in DONE, so it is exactly one cycle wide.
  - busy=1 in RUN and DONE.
  - Latency: start accepted at edge 0; done high in the cycle after edge NIB.
  - sum, cout and overflow hold the previous result throughout RUN. They change only on the RUN→DONE edge, and hold until the next completion or reset.
- Boundary conditions:
  - start while busy=1 is ignored (no queueing); a, b and cin changes during RUN have no effect.
  - start asserted continuously: a new operation is accepted on the first edge in IDLE after DONE, so the cadence is NIB+2 cycles per operation.
  - WIDTH=4: RUN lasts exactly one cycle.
  - cin=1 with all-ones operands: the carry ripples through every nibble. Result is sum = all ones, cout=1.
- Widths:
  - Counter width is clog2(NIB), minimum 1 bit.
  - Arithmetic is unsigned modulo 2^WIDTH; cout is the carry out of bit WIDTH-1.

Decomposition:
- Shared header: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the NIBBLE_W=4 constant.
- One sub-module: the existing carry_lookahead_adder_4bit, instantiated once as the combinational nibble stage. No other hierarchy.

Test Plan:
- WIDTH=16, a=16'h1234, b=16'h4321, cin=0, start pulse → done exactly 4 cycles after the accept edge; sum=16'h5555, cout=0, overflow=0; busy high for 5 cycles.
- a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1, overflow=0. Also a=16'hFFFF, b=16'hFFFF, cin=1 → sum=16'hFFFF, cout=1.
- a=16'h7FFF, b=16'h0001 → sum=16'h8000, cout=0, overflow=1. Also a=16'h8000, b=16'h8000 → sum=16'h0000, cout=1, overflow=1.
- First op 16'h0F0F+16'h00F1. Pulse start with a=16'hAAAA at RUN cycle 2 → ignored; result 16'h1000, single done pulse. sum shows the prior value until the completion edge.
- Start an op, then drop rst_n mid-RUN for 1 cycle → all outputs 0 immediately (asynchronous), no done. After release, a new op 16'h0001+16'h0001 → sum=16'h0002.
- start held high for 3 operations → accept edges exactly NIB+2 = 6 cycles apart. Rerun the first scenario at WIDTH=4 (a=4'h9, b=4'h8 → sum=4'h1, cout=1, overflow=1, done 1 cycle after accept).
